// File: rtl/gfx_pkg.sv
// gfx_pkg: shared framebuffer geometry, pixel/history records and writer states
package gfx_pkg;

  localparam int COORD_WIDTH     = 32;
  localparam int DEPTH_BIT_WIDTH = 16;
  localparam int COLOR_WIDTH     = 8;
  localparam int FB_WIDTH        = 320;
  localparam int FB_HEIGHT       = 180;
  localparam int FB_PIXELS       = FB_WIDTH * FB_HEIGHT;
  localparam int ADDR_WIDTH      = $clog2(FB_PIXELS);
  localparam int HIST_DEPTH      = 3;

  localparam logic [COLOR_WIDTH-1:0]     CLEAR_COLOR = 8'h00;
  localparam logic [DEPTH_BIT_WIDTH-1:0] DEPTH_FAR   = 16'hFFFF;
  localparam logic [ADDR_WIDTH-1:0]      LAST_ADDR   = ADDR_WIDTH'(FB_PIXELS - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]      addr;
    logic [DEPTH_BIT_WIDTH-1:0] depth;
    logic [COLOR_WIDTH-1:0]     color;
  } pixel_t;

  typedef struct packed {
    logic                       valid;
    logic [ADDR_WIDTH-1:0]      addr;
    logic [DEPTH_BIT_WIDTH-1:0] depth;
  } hist_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } wr_state_t;

  // Signed on-screen test; negative coordinates must never alias into the frame
  function automatic logic in_frame(input logic signed [COORD_WIDTH-1:0] px,
                                    input logic signed [COORD_WIDTH-1:0] py);
    return (px >= 32'sd0) && (px < FB_WIDTH) && (py >= 32'sd0) && (py < FB_HEIGHT);
  endfunction

  // Row-major linear address, truncated to the BRAM address width
  function automatic logic [ADDR_WIDTH-1:0] pixel_addr(input logic signed [COORD_WIDTH-1:0] px,
                                                       input logic signed [COORD_WIDTH-1:0] py);
    return ADDR_WIDTH'(py * FB_WIDTH + px);
  endfunction

endpackage

// File: rtl/depth_forward_buffer.sv
// depth_forward_buffer: remembers the last three depth writes so the compare
// stage sees values the BRAM read port has not caught up with yet.
module depth_forward_buffer
  import gfx_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  hist_t                      i_push,
  input  logic [ADDR_WIDTH-1:0]      i_lookup_addr,
  input  logic [DEPTH_BIT_WIDTH-1:0] i_rd_depth,
  output logic [DEPTH_BIT_WIDTH-1:0] o_depth
);

  hist_t                r_hist [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] w_match;

  // Shift history: entry 0 mirrors the write currently on the BRAM port
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        r_hist[i] <= '0;
      end
    end else begin
      r_hist[0] <= i_push;
      for (int i = 1; i < HIST_DEPTH; i++) begin
        r_hist[i] <= r_hist[i-1];
      end
    end
  end

  // Address match per history entry
  always_comb begin
    w_match = '0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      w_match[i] = r_hist[i].valid && (r_hist[i].addr == i_lookup_addr);
    end
  end

  // Newest matching entry wins; otherwise the BRAM value stands
  always_comb begin
    o_depth = i_rd_depth;
    if (w_match[0]) begin
      o_depth = r_hist[0].depth;
    end else if (w_match[1]) begin
      o_depth = r_hist[1].depth;
    end else if (w_match[2]) begin
      o_depth = r_hist[2].depth;
    end else begin
      o_depth = i_rd_depth;
    end
  end

endmodule

// File: rtl/depth_test_writer.sv
// depth_test_writer: pipelined z-buffer read/compare/write into depth and
// framebuffer BRAMs, plus a full-frame clear sweep. Geometry lives in gfx_pkg.
module depth_test_writer
  import gfx_pkg::*;
(
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic signed [COORD_WIDTH-1:0] x,
  input  logic signed [COORD_WIDTH-1:0] y,
  input  logic [DEPTH_BIT_WIDTH-1:0]    depth,
  input  logic [COLOR_WIDTH-1:0]        color,
  input  logic                          drawing,
  input  logic                          clear_start,
  output logic [ADDR_WIDTH-1:0]         depth_rd_addr,
  input  logic [DEPTH_BIT_WIDTH-1:0]    depth_rd_data,
  output logic [ADDR_WIDTH-1:0]         depth_wr_addr,
  output logic [DEPTH_BIT_WIDTH-1:0]    depth_wr_data,
  output logic                          depth_we,
  output logic [ADDR_WIDTH-1:0]         fb_addr,
  output logic [COLOR_WIDTH-1:0]        fb_data,
  output logic                          fb_we,
  output logic                          busy,
  output logic                          clear_done,
  output logic [31:0]                   pix_written
);

  wr_state_t                  r_state;
  logic                       r_s0_valid, r_s1_valid, r_s2_valid;
  pixel_t                     r_s0, r_s1, r_s2;
  logic [ADDR_WIDTH-1:0]      r_clr_addr;
  logic                       r_clr_last;
  logic                       r_we;
  logic                       r_wr_is_pix;
  logic [ADDR_WIDTH-1:0]      r_wr_addr;
  logic [DEPTH_BIT_WIDTH-1:0] r_wr_depth;
  logic [COLOR_WIDTH-1:0]     r_wr_color;
  logic                       r_clear_done;
  logic                       r_busy;
  logic [31:0]                r_pix_written;

  logic                       w_accept;
  pixel_t                     w_s0_next;
  logic [DEPTH_BIT_WIDTH-1:0] w_stored;
  logic                       w_pix_wr;
  hist_t                      w_push;
  logic                       w_flush;
  logic                       w_pipe_empty;
  logic                       w_busy_next;

  // Admission: IDLE only, never alongside a clear request, on-screen only
  assign w_accept     = (r_state == IDLE) && drawing && !clear_start && in_frame(x, y);
  assign w_s0_next    = {pixel_addr(x, y), depth, color};
  assign w_pix_wr     = r_s2_valid && (r_s2.depth < w_stored);
  assign w_push       = {w_pix_wr, r_s2.addr, r_s2.depth};
  assign w_flush      = (r_state == CLEAR);
  assign w_pipe_empty = !r_s0_valid && !r_s1_valid && !r_s2_valid;
  assign w_busy_next  = (r_state != IDLE) || clear_start || w_accept || r_s0_valid || r_s1_valid;

  depth_forward_buffer u_fwd (
    .i_clk         (clk_in),
    .i_rst         (rst_in),
    .i_flush       (w_flush),
    .i_push        (w_push),
    .i_lookup_addr (r_s2.addr),
    .i_rd_depth    (depth_rd_data),
    .o_depth       (w_stored)
  );

  // Pixel pipeline: S0 register, S1/S2 cover the two-cycle BRAM read
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s0_valid <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s0       <= '0;
      r_s1       <= '0;
      r_s2       <= '0;
    end else begin
      r_s0_valid <= w_accept;
      if (w_accept) begin
        r_s0 <= w_s0_next;
      end else begin
        r_s0 <= r_s0;
      end
      r_s1_valid <= r_s0_valid;
      r_s1       <= r_s0;
      r_s2_valid <= r_s1_valid;
      r_s2       <= r_s1;
    end
  end

  // Mode FSM, clear sweep, registered BRAM write port, status and pixel count
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= IDLE;
      r_clr_addr    <= '0;
      r_clr_last    <= 1'b0;
      r_we          <= 1'b0;
      r_wr_is_pix   <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_depth    <= '0;
      r_wr_color    <= '0;
      r_clear_done  <= 1'b0;
      r_busy        <= 1'b0;
      r_pix_written <= 32'd0;
    end else begin
      r_busy       <= w_busy_next;
      r_clear_done <= r_clr_last;
      r_clr_last   <= 1'b0;

      // A clear request restarts the count even if a pixel write is on the port
      if ((r_state == IDLE) && clear_start) begin
        r_pix_written <= 32'd0;
      end else if (r_wr_is_pix && (r_pix_written != 32'hFFFF_FFFF)) begin
        r_pix_written <= r_pix_written + 32'd1;
      end else begin
        r_pix_written <= r_pix_written;
      end

      case (r_state)
        IDLE: begin
          if (clear_start) begin
            r_state <= DRAIN;
          end else begin
            r_state <= IDLE;
          end
        end
        DRAIN: begin
          if (w_pipe_empty) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
          end else begin
            r_state <= DRAIN;
          end
        end
        CLEAR: begin
          if (r_clr_addr == LAST_ADDR) begin
            r_state    <= IDLE;
            r_clr_addr <= '0;
            r_clr_last <= 1'b1;
          end else begin
            r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1'b1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      // Depth and framebuffer share one address and one enable
      if (r_state == CLEAR) begin
        r_we        <= 1'b1;
        r_wr_is_pix <= 1'b0;
        r_wr_addr   <= r_clr_addr;
        r_wr_depth  <= DEPTH_FAR;
        r_wr_color  <= CLEAR_COLOR;
      end else if (w_pix_wr) begin
        r_we        <= 1'b1;
        r_wr_is_pix <= 1'b1;
        r_wr_addr   <= r_s2.addr;
        r_wr_depth  <= r_s2.depth;
        r_wr_color  <= r_s2.color;
      end else begin
        r_we        <= 1'b0;
        r_wr_is_pix <= 1'b0;
      end
    end
  end

  assign depth_rd_addr = r_s0.addr;
  assign depth_wr_addr = r_wr_addr;
  assign depth_wr_data = r_wr_depth;
  assign depth_we      = r_we;
  assign fb_addr       = r_wr_addr;
  assign fb_data       = r_wr_color;
  assign fb_we         = r_we;
  assign busy          = r_busy;
  assign clear_done    = r_clear_done;
  assign pix_written   = r_pix_written;

endmodule

// File: tb/tb_depth_test_writer.sv
// tb_depth_test_writer: directed and random pixels against a serial z-buffer model
module tb_depth_test_writer;

  localparam int W = 320;
  localparam int H = 180;
  localparam int NPIX = W * H;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic signed [31:0] x, y;
  logic [15:0]        depth;
  logic [7:0]         color;
  logic               drawing, clear_start;
  logic [15:0]        depth_rd_addr, depth_wr_addr, fb_addr;
  logic [15:0]        depth_rd_data, depth_wr_data;
  logic [7:0]         fb_data;
  logic               depth_we, fb_we, busy, clear_done;
  logic [31:0]        pix_written;

  depth_test_writer dut (
    .clk_in(clk_in), .rst_in(rst_in), .x(x), .y(y), .depth(depth), .color(color),
    .drawing(drawing), .clear_start(clear_start),
    .depth_rd_addr(depth_rd_addr), .depth_rd_data(depth_rd_data),
    .depth_wr_addr(depth_wr_addr), .depth_wr_data(depth_wr_data), .depth_we(depth_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
    .busy(busy), .clear_done(clear_done), .pix_written(pix_written)
  );

  always #5 clk_in = ~clk_in;

  // Depth BRAM: port A read latency 2, port B write
  logic [15:0] dmem [NPIX];
  logic [15:0] rd_p1;
  initial begin
    for (int i = 0; i < NPIX; i++) dmem[i] = 16'h0;
    rd_p1 = 16'h0;
    depth_rd_data = 16'h0;
  end
  always @(posedge clk_in) begin
    rd_p1 <= (int'(depth_rd_addr) < NPIX) ? dmem[depth_rd_addr] : 16'h0;
    depth_rd_data <= rd_p1;
    if (depth_we && int'(depth_wr_addr) < NPIX) dmem[depth_wr_addr] <= depth_wr_data;
  end

  // Write monitor
  logic [39:0] act_q[$];
  logic [39:0] exp_q[$];
  bit in_clear = 0;
  int clr_cnt = 0, clr_bad = 0, pair_bad = 0, done_cnt = 0;
  int negcnt = 0, last_clr_neg = -100, done_neg = -1;
  always @(negedge clk_in) begin
    negcnt++;
    if (fb_we) begin
      if (!depth_we || depth_wr_addr != fb_addr) pair_bad++;
      if (in_clear) begin
        if (int'(fb_addr) != clr_cnt || depth_wr_data != 16'hFFFF || fb_data != 8'h00) clr_bad++;
        clr_cnt++;
        last_clr_neg = negcnt;
      end else begin
        act_q.push_back({fb_addr, depth_wr_data, fb_data});
      end
    end else if (depth_we) begin
      pair_bad++;
    end
    if (clear_done) begin
      done_cnt++;
      done_neg = negcnt;
    end
  end

  int errors = 0, checks = 0;
  int zmod [NPIX];
  int pw_model = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one input cycle and apply the serial z-buffer rule to the model
  task automatic drive(input int px, input int py, input int pd, input int pc, input bit drw);
    int a;
    @(negedge clk_in);
    x = px; y = py; depth = pd[15:0]; color = pc[7:0]; drawing = drw;
    if (drw && px >= 0 && px < W && py >= 0 && py < H) begin
      a = py * W + px;
      if (pd < zmod[a]) begin
        zmod[a] = pd;
        exp_q.push_back({a[15:0], pd[15:0], pc[7:0]});
        pw_model++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      drawing = 1'b0;
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    #1;
    check({tag, "_count"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_wr%0d", tag, i), act_q[i], exp_q[i]);
    check({tag, "_pixcnt"}, pix_written, pw_model);
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bit seen;
    bit busy_mid;
    int px, py;
    rst_in = 1'b1; x = 0; y = 0; depth = 16'h0; color = 8'h0; drawing = 1'b0; clear_start = 1'b0;
    repeat (3) @(negedge clk_in);
    #1;
    check("rst_fb_we", fb_we, 0);
    check("rst_depth_we", depth_we, 0);
    check("rst_busy", busy, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_pix_written", pix_written, 0);
    check("rst_rd_addr", depth_rd_addr, 0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // 1: full clear; a pixel in the request cycle must be dropped
    in_clear = 1; clr_cnt = 0;
    @(negedge clk_in);
    clear_start = 1'b1; drawing = 1'b1; x = 1; y = 1; depth = 16'h0; color = 8'h11;
    @(negedge clk_in);
    clear_start = 1'b0; drawing = 1'b0;
    seen = 0; busy_mid = 0;
    for (int i = 0; i < 60000 && !seen; i++) begin
      @(negedge clk_in);
      #1;
      if (i == 100) busy_mid = busy;
      if (clear_done) seen = 1;
    end
    check("clr_done_seen", seen, 1);
    check("clr_busy_mid", busy_mid, 1);
    check("clr_count", clr_cnt, NPIX);
    check("clr_done_timing", done_neg, last_clr_neg + 1);
    @(negedge clk_in);
    #1;
    check("clr_busy_after", busy, 0);
    idle(5);
    in_clear = 0;
    check("clr_bad", clr_bad, 0);
    check("clr_done_once", done_cnt, 1);
    check("clr_pix_written", pix_written, 0);
    for (int i = 0; i < NPIX; i++) zmod[i] = 65535;
    pw_model = 0;
    act_q.delete();

    // 2: single pixel latency and contents, then a farther one at the same spot
    drive(10, 5, 100, 8'hAB, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_in);
      drawing = 1'b0;
      #1;
      if (k == 1) check("t2_busy", busy, 1);
      if (k < 4) check($sformatf("t2_early_we%0d", k), fb_we, 0);
    end
    check("t2_fb_we", fb_we, 1);
    check("t2_depth_we", depth_we, 1);
    check("t2_fb_addr", fb_addr, 1610);
    check("t2_fb_data", fb_data, 8'hAB);
    check("t2_depth", depth_wr_data, 100);
    idle(8);
    drive(10, 5, 200, 8'hCD, 1);
    idle(8);
    compare_writes("t2");

    // 3: back-to-back hazards on one address
    drive(3, 3, 50, 8'h01, 1);
    drive(3, 3, 40, 8'h02, 1);
    drive(3, 3, 60, 8'h03, 1);
    idle(8);
    drive(3, 3, 45, 8'h04, 1);
    idle(8);
    compare_writes("t3");
    check("t3_final_depth", dmem[3 * W + 3], zmod[3 * W + 3]);

    // 4: off-screen pixels plus the far corner
    drive(-1, 0, 1, 8'h10, 1);
    drive(320, 0, 1, 8'h11, 1);
    drive(0, 180, 1, 8'h12, 1);
    drive(0, -1, 1, 8'h13, 1);
    drive(319, 179, 5, 8'h14, 1);
    idle(8);
    compare_writes("t4");

    // 5: equal depth loses
    drive(7, 7, 90, 8'h21, 1);
    drive(7, 7, 90, 8'h22, 1);
    idle(8);
    compare_writes("t5");

    // Random stream over a small hot region to provoke hazards and ties
    for (int i = 0; i < 400; i++) begin
      px = int'($urandom_range(9, 0)) - 2;
      py = int'($urandom_range(3, 0)) - 1;
      if ($urandom_range(15, 0) == 0) px = int'($urandom);
      if ($urandom_range(15, 0) == 0) begin px = 319; py = 179; end
      drive(px, py, int'($urandom_range(300, 0)), int'($urandom_range(255, 0)),
            $urandom_range(3, 0) != 0);
    end
    idle(8);
    compare_writes("rand");
    check("pair_bad", pair_bad, 0);

    // 6: reset in mid-clear aborts without clear_done
    in_clear = 1; clr_cnt = 0;
    @(negedge clk_in);
    clear_start = 1'b1;
    @(negedge clk_in);
    clear_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk_in);
      #1;
      if (clr_cnt >= 1001) seen = 1;
    end
    check("t6_reached_1000", seen, 1);
    rst_in = 1'b1;
    @(negedge clk_in);
    #1;
    check("t6_rst_we", fb_we, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", clear_done, 0);
    check("t6_rst_pix", pix_written, 0);
    check("t6_rst_addr", fb_addr, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    in_clear = 0;
    act_q.delete();
    idle(200);
    check("t6_no_done", done_cnt, 1);
    for (int i = 0; i <= 1000; i++) zmod[i] = 65535;
    pw_model = 0;
    drive(100, 100, 7, 8'h5C, 1);
    idle(8);
    compare_writes("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
